// File: rtl/change_pkg.sv
// change_pkg: state, denomination and strobe encodings shared by
// the change dispenser and its timer.
package change_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    PULSE,
    GAP,
    DONE,
    FAULT
  } state_t;

  localparam logic [7:0] D50 = 8'd50;
  localparam logic [7:0] D10 = 8'd10;
  localparam logic [7:0] D5  = 8'd5;
  localparam logic [7:0] D1  = 8'd1;

  // one-hot strobe bit index per denomination
  localparam int unsigned S1  = 0;
  localparam int unsigned S5  = 1;
  localparam int unsigned S10 = 2;
  localparam int unsigned S50 = 3;

  typedef logic [3:0] strobe_t;

  // value of the coin selected by a one-hot strobe
  function automatic logic [7:0] denom(
    input strobe_t s
  );
    logic [7:0] v;
    v = 8'd0;
    if (s[S50])      v = D50;
    else if (s[S10]) v = D10;
    else if (s[S5])  v = D5;
    else if (s[S1])  v = D1;
    return v;
  endfunction

  // greedy pick: largest non-empty coin not above rem
  function automatic strobe_t pick(
    input logic [7:0] rem,
    input logic [3:0] empty
  );
    strobe_t s;
    s = '0;
    if (!empty[S50] && rem >= D50)      s[S50] = 1'b1;
    else if (!empty[S10] && rem >= D10) s[S10] = 1'b1;
    else if (!empty[S5] && rem >= D5)   s[S5] = 1'b1;
    else if (!empty[S1] && rem >= D1)   s[S1] = 1'b1;
    return s;
  endfunction

endpackage

// File: rtl/change_dispenser_timer.sv
// dispense_timer: loadable down-counter; expire is high
// while the count sits at zero.
module dispense_timer #(
  parameter int W = 16
) (
  input  logic         clk_sys,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expire
);

  logic [W-1:0] cnt;

  // load wins; otherwise count down and park at zero
  always_ff @(posedge clk_sys) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= value;
    else if (cnt != '0)
      cnt <= cnt - W'(1);
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: pays change as greedy one-hot hopper strobes.
// Optional completion tone: define CHANGE_BEEP_EN.
module change_dispenser
  import change_pkg::*;
#(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 4,
  parameter int BEEP_CYCLES  = 8
) (
  input  logic       clk_sys,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] amount,
  input  logic       empty50,
  input  logic       empty10,
  input  logic       empty5,
  input  logic       empty1,
  input  logic       clear,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic       disp50,
  output logic       disp10,
  output logic       disp5,
  output logic       disp1,
  output logic [7:0] remaining,
  output logic       beep
);

  localparam int TW = 16;

  if (PULSE_CYCLES < 1 || GAP_CYCLES < 1 ||
      BEEP_CYCLES < 1) begin : g_bad_param
    $error("cycle parameters must be >= 1");
  end

  state_t        state, state_d;
  logic [7:0]    rem_q, rem_d;
  strobe_t       strobe_q, strobe_d;
  strobe_t       sel;
  logic          t_load;
  logic [TW-1:0] t_value;
  logic          t_expire;

  assign sel = pick(rem_q,
                    {empty50, empty10, empty5, empty1});

  dispense_timer #(.W(TW)) u_timer (
    .clk_sys (clk_sys),
    .rst     (rst),
    .load    (t_load),
    .value   (t_value),
    .expire  (t_expire)
  );

  // state, owed amount and strobe registers
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state    <= IDLE;
      rem_q    <= '0;
      strobe_q <= '0;
    end else begin
      state    <= state_d;
      rem_q    <= rem_d;
      strobe_q <= strobe_d;
    end
  end

  // next state, payout bookkeeping and timer loads
  always_comb begin
    state_d  = state;
    rem_d    = rem_q;
    strobe_d = strobe_q;
    t_load   = 1'b0;
    t_value  = '0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (amount != 8'd0) begin
            rem_d   = amount;
            state_d = SELECT;
          end else begin
            state_d = DONE;
          end
        end
      end
      SELECT: begin
        if (sel == '0) begin
          state_d = FAULT;
        end else begin
          strobe_d = sel;
          t_load   = 1'b1;
          t_value  = TW'(PULSE_CYCLES - 1);
          state_d  = PULSE;
        end
      end
      PULSE: begin
        if (t_expire) begin
          rem_d    = rem_q - denom(strobe_q);
          strobe_d = '0;
          t_load   = 1'b1;
          t_value  = TW'(GAP_CYCLES - 1);
          state_d  = GAP;
        end
      end
      GAP: begin
        if (t_expire)
          state_d = (rem_q == 8'd0) ? DONE : SELECT;
      end
      DONE: begin
        state_d = IDLE;
      end
      FAULT: begin
        if (clear) begin
          rem_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d  = IDLE;
        strobe_d = '0;
      end
    endcase
  end

  assign busy = (state == SELECT) ||
                (state == PULSE) ||
                (state == GAP);
  assign done      = (state == DONE);
  assign fault     = (state == FAULT);
  assign remaining = rem_q;
  assign disp50    = strobe_q[S50];
  assign disp10    = strobe_q[S10];
  assign disp5     = strobe_q[S5];
  assign disp1     = strobe_q[S1];

`ifdef CHANGE_BEEP_EN
  logic beep_q;
  logic beep_load;
  logic beep_expire;

  assign beep_load =
    (state_d == DONE  && state != DONE) ||
    (state_d == FAULT && state != FAULT);

  dispense_timer #(.W(TW)) u_beep (
    .clk_sys (clk_sys),
    .rst     (rst),
    .load    (beep_load),
    .value   (TW'(BEEP_CYCLES - 1)),
    .expire  (beep_expire)
  );

  // tone starts with DONE/FAULT entry, ends when count hits zero
  always_ff @(posedge clk_sys) begin
    if (rst)
      beep_q <= 1'b0;
    else if (beep_load)
      beep_q <= 1'b1;
    else if (beep_expire)
      beep_q <= 1'b0;
  end

  assign beep = beep_q;
`else
  assign beep = 1'b0;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: random change requests against a greedy
// payout model; a monitor pops expected events as the DUT acts.
module tb_change_dispenser;

  localparam int P = 2;
  localparam int G = 1;
  localparam int B = 3;
  localparam int C = 1 + P + G;

  localparam int K_COIN  = 0;
  localparam int K_DONE  = 1;
  localparam int K_FAULT = 2;

  logic       clk_sys = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] amount = 8'd0;
  logic       empty50 = 1'b0;
  logic       empty10 = 1'b0;
  logic       empty5 = 1'b0;
  logic       empty1 = 1'b0;
  logic       clear = 1'b0;
  logic       busy, done, fault;
  logic       disp50, disp10, disp5, disp1;
  logic [7:0] remaining;
  logic       beep;

  change_dispenser #(
    .PULSE_CYCLES (P),
    .GAP_CYCLES   (G),
    .BEEP_CYCLES  (B)
  ) dut (
    .clk_sys   (clk_sys),
    .rst       (rst),
    .start     (start),
    .amount    (amount),
    .empty50   (empty50),
    .empty10   (empty10),
    .empty5    (empty5),
    .empty1    (empty1),
    .clear     (clear),
    .busy      (busy),
    .done      (done),
    .fault     (fault),
    .disp50    (disp50),
    .disp10    (disp10),
    .disp5     (disp5),
    .disp1     (disp1),
    .remaining (remaining),
    .beep      (beep)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    int kind;
    int val;
    int rem;
    int cyc;
  } ev_t;

  ev_t q[$];
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  ends = 0;
  bit  mon_en = 1'b0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  function automatic int den(logic [3:0] s);
    case (s)
      4'b1000: return 50;
      4'b0100: return 10;
      4'b0010: return 5;
      4'b0001: return 1;
      default: return -1;
    endcase
  endfunction

  task automatic push(int k, int v, int r, int c);
    ev_t e;
    e.kind = k;
    e.val = v;
    e.rem = r;
    e.cyc = c;
    q.push_back(e);
  endtask

  // greedy payout from the coin list; emp = {e50,e10,e5,e1}
  task automatic model(int amt, bit [3:0] emp, int t0);
    int dn[4] = '{50, 10, 5, 1};
    int rem = amt;
    int n = 0;
    int d;
    if (amt == 0) begin
      push(K_DONE, 0, 0, t0 + 1);
      return;
    end
    forever begin
      d = 0;
      for (int i = 0; i < 4; i++)
        if (d == 0 && !emp[3-i] && dn[i] <= rem)
          d = dn[i];
      if (d == 0) begin
        push(K_FAULT, 0, rem, t0 + 2 + n * C);
        return;
      end
      push(K_COIN, d, rem, 0);
      rem -= d;
      n++;
      if (rem == 0) begin
        push(K_DONE, 0, 0, t0 + 1 + n * C);
        return;
      end
    end
  endtask

  // monitor: sample on falling edge, pop on DUT events
  logic [3:0] prev_s;
  logic       prev_fault;
  int         plen;
  int         beep_left;

  always @(negedge clk_sys) begin : mon
    logic [3:0] s;
    ev_t e;
    s = {disp50, disp10, disp5, disp1};
    if (rst || !mon_en) begin
      prev_s = '0;
      prev_fault = 1'b0;
      plen = 0;
      beep_left = 0;
    end else begin
      chk("onehot", int'($countones(s) <= 1), 1);
      if (s != 0) plen++;
      if (s != 0 && prev_s == 0) begin
        if (q.size() == 0) begin
          chk("coin_unexpected", 0, 1);
        end else begin
          e = q.pop_front();
          chk("coin_kind", e.kind, K_COIN);
          chk("coin_denom", den(s), e.val);
          chk("coin_rem", int'(remaining), e.rem);
          chk("coin_busy", int'(busy), 1);
        end
      end
      if (s == 0 && prev_s != 0) begin
        chk("pulse_len", plen, P);
        plen = 0;
      end
      if (done) begin
        ends++;
        if (q.size() == 0) begin
          chk("done_unexpected", 0, 1);
        end else begin
          e = q.pop_front();
          chk("done_kind", e.kind, K_DONE);
          chk("done_cycle", cyc, e.cyc);
          chk("done_rem", int'(remaining), 0);
          chk("done_busy", int'(busy), 0);
        end
      end
      if (fault && !prev_fault) begin
        ends++;
        if (q.size() == 0) begin
          chk("fault_unexpected", 0, 1);
        end else begin
          e = q.pop_front();
          chk("fault_kind", e.kind, K_FAULT);
          chk("fault_cycle", cyc, e.cyc);
          chk("fault_rem", int'(remaining), e.rem);
          chk("fault_busy", int'(busy), 0);
        end
      end
`ifdef CHANGE_BEEP_EN
      if (done || (fault && !prev_fault))
        beep_left = B;
      chk("beep", int'(beep), int'(beep_left > 0));
      if (beep_left > 0) beep_left--;
`else
      chk("beep_off", int'(beep), 0);
`endif
      prev_s = s;
      prev_fault = fault;
    end
  end

  task automatic do_reset();
    @(posedge clk_sys); #1;
    rst = 1'b1;
    start = 1'b0;
    clear = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1 rst = 1'b0;
    q.delete();
  endtask

  task automatic run_tx(int amt, bit [3:0] emp, bit inj);
    int e0;
    bit got;
    @(posedge clk_sys); #1;
    {empty50, empty10, empty5, empty1} = emp;
    amount = 8'(amt);
    start = 1'b1;
    e0 = ends;
    model(amt, emp, cyc);
    @(posedge clk_sys); #1;
    start = 1'b0;
    amount = 8'($urandom);
    if (inj && amt != 0) begin
      @(posedge clk_sys); #1;
      @(posedge clk_sys); #1;
      start = 1'b1;
      amount = 8'd20;
      @(posedge clk_sys); #1;
      start = 1'b0;
    end
    got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk_sys);
      if (ends > e0) got = 1'b1;
    end
    if (!got) begin
      chk("tx_timeout", 0, 1);
      do_reset();
      return;
    end
    if (fault) begin
      @(posedge clk_sys); #1;
      clear = 1'b1;
      @(posedge clk_sys); #1;
      clear = 1'b0;
      @(negedge clk_sys);
      chk("clear_rem", int'(remaining), 0);
      chk("clear_fault", int'(fault), 0);
    end
  endtask

  initial begin : stim
    int a;
    bit [3:0] em;
    bit got;
    repeat (3) @(posedge clk_sys);
    #1 rst = 1'b0;
    @(negedge clk_sys);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_disp",
        int'({disp50, disp10, disp5, disp1}), 0);
    chk("rst_rem", int'(remaining), 0);
    chk("rst_beep", int'(beep), 0);
    mon_en = 1'b1;

    run_tx(7, 4'b0000, 1'b0);
    run_tx(0, 4'b0000, 1'b0);
    run_tx(66, 4'b0100, 1'b0);
    run_tx(3, 4'b0001, 1'b0);
    run_tx(10, 4'b0000, 1'b0);
    run_tx(55, 4'b0000, 1'b1);
    run_tx(1, 4'b0000, 1'b0);
    run_tx(255, 4'b0000, 1'b0);
    run_tx(255, 4'b1100, 1'b0);
    run_tx(4, 4'b1111, 1'b1);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0)
        a = $urandom_range(0, 12);
      else
        a = $urandom_range(0, 255);
      for (int k = 0; k < 4; k++)
        em[k] = ($urandom_range(0, 3) == 0);
      run_tx(a, em, 1'($urandom_range(0, 1)));
    end

    // reset in the middle of a 50 strobe
    @(posedge clk_sys); #1;
    {empty50, empty10, empty5, empty1} = 4'b0000;
    amount = 8'd55;
    start = 1'b1;
    model(55, 4'b0000, cyc);
    @(posedge clk_sys); #1;
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk_sys);
      if (disp50) got = 1'b1;
    end
    chk("rst_mid_seen50", int'(got), 1);
    @(posedge clk_sys); #1;
    rst = 1'b1;
    @(negedge clk_sys);
    chk("rst_mid_hold50", int'(disp50), 1);
    @(negedge clk_sys);
    chk("rst_mid_disp50", int'(disp50), 0);
    chk("rst_mid_rem", int'(remaining), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_done", int'(done), 0);
    @(posedge clk_sys); #1;
    rst = 1'b0;
    q.delete();
    @(negedge clk_sys);
    chk("rst_mid_idle_busy", int'(busy), 0);

    run_tx(10, 4'b0000, 1'b0);
    chk("queue_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
